dds_mod_sequencer: RTL and testbench

- Controller that drives the modulation datapath's `modulation[3:0]` select and its `lfsr_mod` data bit.
- Generates the symbol-rate timebase and the 5-bit LFSR data pattern, and selects the FSK phase increment for the DDS accumulator.
- Accepts mode/baud reconfiguration over a valid/ready handshake and commits changes only on symbol boundaries, so the modulator output never glitches mid-symbol.
- Sits in the fast clock domain, directly upstream of the modulator.

---
 rtl/dds_mod_sequencer_if.sv | 20 ++
 rtl/dds_mod_sequencer.sv | 176 +++++++++++++++++
 tb/tb_dds_mod_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_mod_sequencer_if.sv
// Configuration handshake bundle for dds_mod_sequencer.
// The master requests a mode/baud change; the slave (sequencer) reports
// readiness and flags illegal modes with a one-cycle error pulse.
interface dds_mod_sequencer_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_mode;
  logic [15:0] cfg_baud_div;
  logic        cfg_err;

  modport master (
    output cfg_valid, cfg_mode, cfg_baud_div,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_baud_div,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/dds_mod_sequencer.sv
// dds_mod_sequencer: symbol timebase, 5-bit LFSR data source and FSK tuning
// word select for the DDS modulator. Mode/baud changes arrive over a
// valid/ready handshake and are committed only on symbol boundaries while
// running, so the modulator never switches mid-symbol.
// Optional feature: define DDS_SEQ_SYMCNT_EN to add the sym_count output.
module dds_mod_sequencer #(
  parameter logic [4:0]  LFSR_SEED    = 5'h1F,
  parameter logic [31:0] F0_INC       = 32'h0100_0000,
  parameter logic [31:0] F1_INC       = 32'h0200_0000,
  parameter logic [15:0] DEF_BAUD_DIV = 16'd999
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  dds_mod_sequencer_if.slave      cfg,
  output logic [3:0]              modulation,
  output logic                    lfsr_mod,
  output logic [31:0]             phase_inc,
  output logic                    sym_tick
`ifdef DDS_SEQ_SYMCNT_EN
  ,
  output logic [15:0]             sym_count
`endif
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [4:0] SEED = (LFSR_SEED == 5'h00) ? 5'h01 : LFSR_SEED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [15:0] baud_reg;
  logic [4:0]  lfsr_reg;
  logic        lfsr_mod_reg;
  logic [31:0] phase_inc_reg;
  logic [3:0]  mod_reg;
  logic        err_reg;
  logic [3:0]  pend_mode_reg;
  logic [15:0] pend_baud_reg;
`ifdef DDS_SEQ_SYMCNT_EN
  logic [15:0] sym_count_reg;
`endif

  logic        tick;
  logic        ready;
  logic        xfer;
  logic        legal;
  logic [4:0]  lfsr_next;
  logic        commit;
  logic [3:0]  commit_mode;
  logic [15:0] commit_baud;
  logic [3:0]  mod_next;
  logic        lfsr_mod_next;

  // The tick is decoded from registered state only, so it is a clean
  // one-cycle pulse on the last count of each symbol.
  assign tick      = (state_reg != IDLE) && (cnt_reg == baud_reg);
  assign ready     = (state_reg != PEND);
  assign xfer      = cfg.cfg_valid && ready;
  assign legal     = (cfg.cfg_mode[3:2] == 2'b00);
  assign lfsr_next = {lfsr_reg[3:0], lfsr_reg[4] ^ lfsr_reg[2]};

  // Decide whether a configuration is applied at the coming edge and with
  // which values: immediately when not running, else at a symbol boundary
  // or when the timebase is stopped with a change still pending.
  always_comb begin
    commit      = 1'b0;
    commit_mode = pend_mode_reg;
    commit_baud = pend_baud_reg;
    case (state_reg)
      IDLE: begin
        if (xfer && legal) begin
          commit      = 1'b1;
          commit_mode = cfg.cfg_mode;
          commit_baud = cfg.cfg_baud_div;
        end
      end
      RUN: begin
        if (xfer && legal && !enable) begin
          commit      = 1'b1;
          commit_mode = cfg.cfg_mode;
          commit_baud = cfg.cfg_baud_div;
        end
      end
      PEND: begin
        if (tick || !enable) begin
          commit = 1'b1;
        end
      end
      default: begin
        commit = 1'b0;
      end
    endcase
    mod_next      = commit ? commit_mode : mod_reg;
    lfsr_mod_next = tick ? lfsr_next[4] : lfsr_mod_reg;
  end

  // Sequencer state, timebase, LFSR and registered modulator outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 16'd0;
      baud_reg      <= DEF_BAUD_DIV;
      lfsr_reg      <= SEED;
      lfsr_mod_reg  <= SEED[4];
      phase_inc_reg <= F0_INC;
      mod_reg       <= 4'd0;
      err_reg       <= 1'b0;
      pend_mode_reg <= 4'd0;
      pend_baud_reg <= 16'd0;
    end else begin
      case (state_reg)
        IDLE: if (enable) state_reg <= RUN;
        RUN: begin
          if (!enable)             state_reg <= IDLE;
          else if (xfer && legal)  state_reg <= PEND;
        end
        PEND: begin
          if (!enable)             state_reg <= IDLE;
          else if (tick)           state_reg <= RUN;
        end
        default:                   state_reg <= IDLE;
      endcase

      // Counter sits at 0 whenever stopped and wraps after the last count.
      if (!enable || (state_reg == IDLE) || tick) begin
        cnt_reg <= 16'd0;
      end else begin
        cnt_reg <= cnt_reg + 16'd1;
      end

      if (tick) begin
        lfsr_reg <= lfsr_next;
      end
      lfsr_mod_reg  <= lfsr_mod_next;
      mod_reg       <= mod_next;
      phase_inc_reg <= ((mod_next == 4'd1) && lfsr_mod_next) ? F1_INC : F0_INC;

      if (commit) begin
        baud_reg <= commit_baud;
      end

      if ((state_reg == RUN) && enable && xfer && legal) begin
        pend_mode_reg <= cfg.cfg_mode;
        pend_baud_reg <= cfg.cfg_baud_div;
      end

      err_reg <= xfer && !legal;
    end
  end

`ifdef DDS_SEQ_SYMCNT_EN
  // Symbol counter restarts with each newly committed configuration.
  always_ff @(posedge clk) begin
    if (reset || commit) begin
      sym_count_reg <= 16'd0;
    end else if (tick) begin
      sym_count_reg <= sym_count_reg + 16'd1;
    end
  end
  assign sym_count = sym_count_reg;
`endif

  assign modulation    = mod_reg;
  assign lfsr_mod      = lfsr_mod_reg;
  assign phase_inc     = phase_inc_reg;
  assign sym_tick      = tick;
  assign cfg.cfg_ready = ready;
  assign cfg.cfg_err   = err_reg;

endmodule

// File: tb/tb_dds_mod_sequencer.sv
// Testbench for dds_mod_sequencer: directed scenarios with literal
// expectations plus a cycle-level reference model compared every cycle.
module tb_dds_mod_sequencer;

  localparam logic [31:0] F0 = 32'h0100_0000;
  localparam logic [31:0] F1 = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  modulation;
  logic        lfsr_mod;
  logic [31:0] phase_inc;
  logic        sym_tick;
`ifdef DDS_SEQ_SYMCNT_EN
  logic [15:0] sym_count;
`endif

  dds_mod_sequencer_if cfg_if ();

  dds_mod_sequencer #(.DEF_BAUD_DIV(16'd3)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cfg        (cfg_if),
    .modulation (modulation),
    .lfsr_mod   (lfsr_mod),
    .phase_inc  (phase_inc),
    .sym_tick   (sym_tick)
`ifdef DDS_SEQ_SYMCNT_EN
    ,
    .sym_count  (sym_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Data bit for each symbol index, straight from the LFSR recurrence.
  logic seq [0:30];
  initial begin
    logic [4:0] l;
    l = 5'h1F;
    for (int i = 0; i < 31; i++) begin
      seq[i] = l[4];
      l = {l[3:0], l[4] ^ l[2]};
    end
  end

  bit m_started = 0;
  bit m_running, m_pending, m_err;
  int m_pos, m_baud, m_mode, m_pmode, m_pbaud, m_idx, m_symcnt;

  always @(posedge clk) begin
    bit t, x, lg, cm;
    int nmode, nbaud;
    t = m_running && (m_pos == m_baud);
    if (reset) begin
      m_started = 1; m_running = 0; m_pending = 0; m_err = 0;
      m_pos = 0; m_baud = 3; m_mode = 0; m_idx = 0; m_symcnt = 0;
      m_pmode = 0; m_pbaud = 0;
    end else if (m_started) begin
      x  = cfg_if.cfg_valid && !m_pending;
      lg = (cfg_if.cfg_mode < 4);
      m_err = x && !lg;
      cm = 0; nmode = m_mode; nbaud = m_baud;
      if (m_pending && (t || !enable)) begin
        cm = 1; nmode = m_pmode; nbaud = m_pbaud;
      end else if (x && lg && (!m_running || !enable)) begin
        cm = 1; nmode = int'(cfg_if.cfg_mode); nbaud = int'(cfg_if.cfg_baud_div);
      end
      if (t) begin
        m_idx = (m_idx + 1) % 31;
        m_symcnt = (m_symcnt + 1) % 65536;
      end
      if (cm) begin
        m_mode = nmode; m_baud = nbaud; m_symcnt = 0;
      end
      if (x && lg && m_running && enable) begin
        m_pending = 1; m_pmode = int'(cfg_if.cfg_mode); m_pbaud = int'(cfg_if.cfg_baud_div);
      end else if (cm) begin
        m_pending = 0;
      end
      m_pos = (m_running && enable && !t) ? m_pos + 1 : 0;
      m_running = enable;
    end
  end

  // Compare every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("m_modulation", {28'd0, modulation}, m_mode);
      chk("m_lfsr_mod", {31'd0, lfsr_mod}, {31'd0, seq[m_idx]});
      chk("m_phase_inc", phase_inc, (m_mode == 1 && seq[m_idx]) ? F1 : F0);
      chk("m_sym_tick", {31'd0, sym_tick}, {31'd0, m_running && (m_pos == m_baud)});
      chk("m_cfg_ready", {31'd0, cfg_if.cfg_ready}, {31'd0, !m_pending});
      chk("m_cfg_err", {31'd0, cfg_if.cfg_err}, {31'd0, m_err});
`ifdef DDS_SEQ_SYMCNT_EN
      chk("m_sym_count", {16'd0, sym_count}, m_symcnt);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance until sym_tick is seen; n = number of cycles advanced.
  task automatic wait_tick(output int n);
    n = 0;
    while (!sym_tick && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_tick: no sym_tick within 100 cycles at %0t", $time);
    end
  endtask

  task automatic send(input logic [3:0] mode, input logic [15:0] baud);
    cfg_if.cfg_valid    = 1'b1;
    cfg_if.cfg_mode     = mode;
    cfg_if.cfg_baud_div = baud;
    step(1);
    cfg_if.cfg_valid    = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mod"},   {28'd0, modulation}, 32'd0);
    chk({tag, "_lfsr"},  {31'd0, lfsr_mod}, 32'd1);
    chk({tag, "_phase"}, phase_inc, F0);
    chk({tag, "_tick"},  {31'd0, sym_tick}, 32'd0);
    chk({tag, "_ready"}, {31'd0, cfg_if.cfg_ready}, 32'd1);
    chk({tag, "_err"},   {31'd0, cfg_if.cfg_err}, 32'd0);
  endtask

  initial begin
    int n;
    logic [4:0] exp_seq;
    logic [5:0] seq_lit;
    reset = 1'b1; enable = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_mode = 4'd0; cfg_if.cfg_baud_div = 16'd0;
    step(2);
    chk_reset_vals("rst");
    // Pin the model's data table to hand-derived LFSR bits.
    seq_lit = {seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]};
    chk("seq_table", {26'd0, seq_lit}, 32'b111110);
    reset = 1'b0;

    // Timebase with divider 3 and data pattern from seed 1F.
    enable = 1'b1;
    wait_tick(n);
    chk("first_tick_delay", n, 32'd4);
    exp_seq = 5'b11110;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("lfsr_seq", {31'd0, lfsr_mod}, {31'd0, exp_seq[4-k]});
      wait_tick(n);
      chk("tick_spacing", n, 32'd3);
    end
    $display("scenario timebase: 5 symbols checked");

    // IDLE commit with divider 0: tick every cycle.
    enable = 1'b0;
    step(1);
    send(4'd1, 16'd0);
    chk("idle_commit_mod", {28'd0, modulation}, 32'd1);
    enable = 1'b1;
    step(1);
    for (int k = 0; k < 6; k++) begin
      chk("tick_every_cycle", {31'd0, sym_tick}, 32'd1);
      step(1);
    end
    $display("scenario fsk baud0: done");

    // Mid-symbol request commits at the boundary.
    enable = 1'b0;
    step(1);
    send(4'd0, 16'd9);
    enable = 1'b1;
    step(1);
    step(3);
    send(4'd2, 16'd9);
    chk("pend_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    wait_tick(n);
    chk("pend_wait", n, 32'd5);
    chk("pend_ready_tick", {31'd0, cfg_if.cfg_ready}, 32'd0);
    chk("pend_mod_old", {28'd0, modulation}, 32'd0);
    step(1);
    chk("pend_mod_new", {28'd0, modulation}, 32'd2);
    chk("pend_ready_back", {31'd0, cfg_if.cfg_ready}, 32'd1);
    $display("scenario boundary commit: done");

    // Request coincident with sym_tick waits one full symbol.
    wait_tick(n);
    send(4'd1, 16'd9);
    chk("coinc_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    chk("coinc_mod_old", {28'd0, modulation}, 32'd2);
    n = 0;
    while (modulation != 4'd1 && n < 50) begin
      step(1);
      n++;
    end
    chk("coinc_delay", n, 32'd10);
    $display("scenario coincident request: delay %0d", n);

    // Illegal mode.
    send(4'd5, 16'd3);
    chk("illegal_err", {31'd0, cfg_if.cfg_err}, 32'd1);
    chk("illegal_mod", {28'd0, modulation}, 32'd1);
    chk("illegal_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    step(1);
    chk("illegal_err_gone", {31'd0, cfg_if.cfg_err}, 32'd0);
    $display("scenario illegal mode: done");

    // Enable drop while pending commits on IDLE entry.
    send(4'd3, 16'd4);
    chk("drop_pend_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    enable = 1'b0;
    step(1);
    chk("drop_mod", {28'd0, modulation}, 32'd3);
    chk("drop_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    chk("drop_tick", {31'd0, sym_tick}, 32'd0);
    $display("scenario enable drop: done");

    // Reset mid-symbol with a pending change discards it.
    enable = 1'b1;
    step(2);
    send(4'd2, 16'd7);
    chk("rst_pend_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    step(1);
    reset = 1'b1;
    step(1);
    chk_reset_vals("rst2");
    reset = 1'b0;
    wait_tick(n);
    chk("rst2_baud", n, 32'd4);
    chk("rst2_mod", {28'd0, modulation}, 32'd0);
    step(5);
    $display("scenario reset: done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
